// File: rtl/t_junction_phase_scheduler.sv
// Demand-actuated phase scheduler for a three-approach T-junction.
// Latches requests, enforces min/max green and passes every change through yellow and all-red.
module t_junction_phase_scheduler #(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1,
  parameter int CW        = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [3:0]    req,
  output logic [2:0]    light_LS,
  output logic [2:0]    light_BR,
  output logic [2:0]    light_LR,
  output logic [2:0]    light_RB,
  output logic          walk,
  output logic [3:0]    grant,
  output logic [3:0]    pending,
  output logic [1:0]    dbg_state,
  output logic [CW-1:0] dbg_cnt
);

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
  } state_t;

  localparam logic [2:0] C_GRN = 3'b001;
  localparam logic [2:0] C_YEL = 3'b010;
  localparam logic [2:0] C_RED = 3'b100;

  state_t        r_state, w_nx_state;
  logic [1:0]    r_cur, w_nx_cur;
  logic [CW-1:0] r_cnt, w_nx_cnt;
  logic [3:0]    r_pending, w_nx_pending;
  logic [2:0]    r_ls, r_br, r_lr, r_rb;
  logic          r_walk;
  logic [3:0]    r_grant;
  logic [CW:0]   w_e;
  logic [3:0]    w_cur_oh;
  logic [3:0]    w_mask;
  logic [2:0]    w_ls, w_br, w_lr, w_rb;

  // Round-robin: nearest set pending bit after cur; P0 when nothing is waiting.
  function automatic logic [1:0] pick_next(input logic [1:0] cur, input logic [3:0] p);
    logic [1:0] res;
    logic [1:0] idx;
    res = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (p[idx]) res = idx;
    end
    return res;
  endfunction

  // Heads that are green in each phase, ordered {LS, BR, LR, RB}.
  function automatic logic [3:0] phase_mask(input logic [1:0] cur);
    case (cur)
      2'd0:    return 4'b1001;
      2'd1:    return 4'b1010;
      2'd2:    return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] head(input state_t st, input logic m);
    if (!m || st == S_ALLRED) return C_RED;
    return (st == S_GREEN) ? C_GRN : C_YEL;
  endfunction

  assign w_e      = {1'b0, r_cnt} + 1'b1;
  assign w_cur_oh = 4'b0001 << r_cur;

  always_comb begin
    w_nx_state = r_state;
    w_nx_cur   = r_cur;
    case (r_state)
      S_GREEN: begin
        if (tick && w_e >= (CW+1)'(MIN_GREEN)
            && (!req[r_cur] || w_e >= (CW+1)'(MAX_GREEN))
            && ((|(r_pending & ~w_cur_oh)) || r_cur != 2'd0))
          w_nx_state = S_YELLOW;
      end
      S_YELLOW: begin
        if (tick && w_e == (CW+1)'(YELLOW)) w_nx_state = S_ALLRED;
      end
      S_ALLRED: begin
        if (tick && w_e == (CW+1)'(ALL_RED)) begin
          w_nx_state = S_GREEN;
          w_nx_cur   = pick_next(r_cur, r_pending);
        end
      end
      default: w_nx_state = S_GREEN;
    endcase
  end

  always_comb begin
    w_nx_cnt     = r_cnt;
    w_nx_pending = r_pending | req;
    if (w_nx_state != r_state) begin
      w_nx_cnt = '0;
    end else if (tick && r_cnt < CW'(MAX_GREEN)) begin
      w_nx_cnt = r_cnt + 1'b1;
    end
    // Clearing the entered phase's bit takes priority over a same-cycle request.
    if (w_nx_state == S_GREEN && r_state != S_GREEN) w_nx_pending[w_nx_cur] = 1'b0;
  end

  always_comb begin
    w_mask = phase_mask(w_nx_cur);
    w_ls   = head(w_nx_state, w_mask[3]);
    w_br   = head(w_nx_state, w_mask[2]);
    w_lr   = head(w_nx_state, w_mask[1]);
    w_rb   = head(w_nx_state, w_mask[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_GREEN;
      r_cur     <= 2'd0;
      r_cnt     <= '0;
      r_pending <= 4'b0000;
      r_ls      <= C_GRN;
      r_br      <= C_RED;
      r_lr      <= C_RED;
      r_rb      <= C_GRN;
      r_walk    <= 1'b0;
      r_grant   <= 4'b0001;
    end else begin
      r_state   <= w_nx_state;
      r_cur     <= w_nx_cur;
      r_cnt     <= w_nx_cnt;
      r_pending <= w_nx_pending;
      r_ls      <= w_ls;
      r_br      <= w_br;
      r_lr      <= w_lr;
      r_rb      <= w_rb;
      r_walk    <= (w_nx_state == S_GREEN) && (w_nx_cur == 2'd3);
      r_grant   <= (w_nx_state == S_GREEN) ? (4'b0001 << w_nx_cur) : 4'b0000;
    end
  end

  assign light_LS  = r_ls;
  assign light_BR  = r_br;
  assign light_LR  = r_lr;
  assign light_RB  = r_rb;
  assign walk      = r_walk;
  assign grant     = r_grant;
  assign pending   = r_pending;
  assign dbg_state = r_state;
  assign dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_t_junction_phase_scheduler.sv
// Directed bench for t_junction_phase_scheduler: linear step sequence plus a per-cycle safety monitor.
module tb_t_junction_phase_scheduler;

  localparam int CW = 5;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [1:0] ST_G = 2'd0;
  localparam logic [1:0] ST_Y = 2'd1;
  localparam logic [1:0] ST_A = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic [3:0]    req = 4'b0000;
  logic [2:0]    light_LS, light_BR, light_LR, light_RB;
  logic          walk;
  logic [3:0]    grant, pending;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_cnt;

  int total = 0;
  int bad   = 0;

  t_junction_phase_scheduler #(
    .MIN_GREEN(5), .MAX_GREEN(10), .YELLOW(2), .ALL_RED(1), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .req(req),
    .light_LS(light_LS), .light_BR(light_BR), .light_LR(light_LR), .light_RB(light_RB),
    .walk(walk), .grant(grant), .pending(pending),
    .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st, input logic [3:0] g,
                         input logic [2:0] ls, input logic [2:0] br, input logic [2:0] lr,
                         input logic [2:0] rb, input logic w);
    chk({tag, ".state"}, 16'(dbg_state), 16'(st));
    chk({tag, ".grant"}, 16'(grant), 16'(g));
    chk({tag, ".heads"}, {4'h0, light_LS, light_BR, light_LR, light_RB}, {4'h0, ls, br, lr, rb});
    chk({tag, ".walk"},  16'(walk), 16'(w));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; req = 4'b0000;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // Safety: green heads must form one phase's set; walk only with every head red.
  always @(negedge clk) begin
    logic [3:0] gm;
    logic legal;
    gm = {light_LS == G, light_BR == G, light_LR == G, light_RB == G};
    legal = (gm == 4'b0000) || (gm == 4'b1001) || (gm == 4'b1010) || (gm == 4'b0100);
    chk("mon.green_set", 16'(legal), 16'd1);
    if (walk)
      chk("mon.walk_red", {4'h0, light_LS, light_BR, light_LR, light_RB}, {4'h0, R, R, R, R});
  end

  initial begin
    // Reset state and P0 resting with no demand
    do_reset();
    chk_out("rst", ST_G, 4'b0001, G, R, R, G, 1'b0);
    chk("rst.pending", 16'(pending), 16'h0);
    chk("rst.cnt", 16'(dbg_cnt), 16'd0);
    ticks(50);
    chk_out("rest", ST_G, 4'b0001, G, R, R, G, 1'b0);
    chk("rest.cnt_sat", 16'(dbg_cnt), 16'd10);

    // Single BR request: gap-out through yellow/all-red to P2 and back
    do_reset();
    req = 4'b0100; cyc(); req = 4'b0000;
    chk("p2.pending_set", 16'(pending), 16'h4);
    ticks(4);
    chk_out("p2.hold_min", ST_G, 4'b0001, G, R, R, G, 1'b0);
    chk("p2.cnt4", 16'(dbg_cnt), 16'd4);
    ticks(1);
    chk_out("p2.y0", ST_Y, 4'b0000, Y, R, R, Y, 1'b0);
    ticks(1);
    chk_out("p2.y1", ST_Y, 4'b0000, Y, R, R, Y, 1'b0);
    ticks(1);
    chk_out("p2.ar", ST_A, 4'b0000, R, R, R, R, 1'b0);
    ticks(1);
    chk_out("p2.green", ST_G, 4'b0100, R, G, R, R, 1'b0);
    chk("p2.pending_clr", 16'(pending), 16'h0);
    ticks(4);
    chk_out("p2.green4", ST_G, 4'b0100, R, G, R, R, 1'b0);
    ticks(1);
    chk_out("p2.yel", ST_Y, 4'b0000, R, Y, R, R, 1'b0);
    ticks(2);
    chk_out("p2.ar2", ST_A, 4'b0000, R, R, R, R, 1'b0);
    ticks(1);
    chk_out("p2.back_p0", ST_G, 4'b0001, G, R, R, G, 1'b0);

    // Held turn request maxes out, then pedestrian phase
    do_reset();
    req = 4'b1010;
    ticks(5);
    chk_out("p1.y", ST_Y, 4'b0000, Y, R, R, Y, 1'b0);
    ticks(2);
    chk_out("p1.ar", ST_A, 4'b0000, R, R, R, R, 1'b0);
    ticks(1);
    chk_out("p1.green", ST_G, 4'b0010, G, R, G, R, 1'b0);
    chk("p1.cnt0", 16'(dbg_cnt), 16'd0);
    ticks(9);
    chk_out("p1.green9", ST_G, 4'b0010, G, R, G, R, 1'b0);
    ticks(1);
    chk_out("p1.maxout", ST_Y, 4'b0000, Y, R, Y, R, 1'b0);
    req = 4'b0000;
    ticks(2);
    chk_out("p1.ar2", ST_A, 4'b0000, R, R, R, R, 1'b0);
    ticks(1);
    chk_out("p3.walk", ST_G, 4'b1000, R, R, R, R, 1'b1);

    // Simultaneous demand: round-robin P1, P2, P3, then rest
    do_reset();
    req = 4'b1110; cyc(); req = 4'b0000;
    chk("rr.pending", 16'(pending), 16'hE);
    ticks(8);
    chk_out("rr.p1", ST_G, 4'b0010, G, R, G, R, 1'b0);
    chk("rr.p1_pend", 16'(pending), 16'hC);
    ticks(5);
    chk_out("rr.p1_y", ST_Y, 4'b0000, Y, R, Y, R, 1'b0);
    ticks(3);
    chk_out("rr.p2", ST_G, 4'b0100, R, G, R, R, 1'b0);
    chk("rr.p2_pend", 16'(pending), 16'h8);
    ticks(8);
    chk_out("rr.p3", ST_G, 4'b1000, R, R, R, R, 1'b1);
    chk("rr.p3_pend", 16'(pending), 16'h0);
    ticks(5);
    chk_out("rr.p3_y", ST_Y, 4'b0000, R, R, R, R, 1'b0);
    ticks(3);
    chk_out("rr.p0", ST_G, 4'b0001, G, R, R, G, 1'b0);

    // Reset during P2 yellow discards state and requests; tick under reset ignored
    do_reset();
    req = 4'b0100; cyc(); req = 4'b0000;
    ticks(8);
    chk_out("mr.p2", ST_G, 4'b0100, R, G, R, R, 1'b0);
    req = 4'b1000; cyc(); req = 4'b0000;
    ticks(5);
    chk_out("mr.p2_y", ST_Y, 4'b0000, R, Y, R, R, 1'b0);
    chk("mr.pend_before", 16'(pending), 16'h8);
    rst = 1'b1; cyc();
    chk_out("mr.rst", ST_G, 4'b0001, G, R, R, G, 1'b0);
    chk("mr.pending", 16'(pending), 16'h0);
    chk("mr.cnt", 16'(dbg_cnt), 16'd0);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("mr.tick_ignored", 16'(dbg_cnt), 16'd0);
    rst = 1'b0; cyc();
    chk("mr.after", 16'(dbg_cnt), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
